// File: rtl/ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle controller: opcode constants,
// ALU operation encodings (also consumed by the ALU), FSM states, instruction
// classes, fault codes and the decoder result payload.
package ctrl_pkg;

    localparam int unsigned OPC_W  = 11;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned FLT_W  = 2;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_PASSB = 3'b100,
        ALU_LSL   = 3'b101,
        ALU_LSR   = 3'b110
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_AND,
        CLS_ORR,
        CLS_LSL,
        CLS_LSR,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_B,
        CLS_NONE
    } instr_class_e;

    typedef enum logic [FLT_W-1:0] {
        FLT_NONE    = 2'b00,
        FLT_ILLEGAL = 2'b01,
        FLT_TIMEOUT = 2'b10
    } fault_e;

    typedef struct packed {
        instr_class_e cls;
        logic         illegal;
    } decode_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier.
//   i_opcode : instr[31:21] of the captured instruction
//   o_dec_c  : instruction class plus illegal flag (CLS_NONE when illegal)
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output decode_t          o_dec_c
);

    // CBZ and B are identified by shorter prefixes; their prefixes never
    // collide with the full 11-bit encodings.
    always_comb begin
        o_dec_c.cls     = CLS_NONE;
        o_dec_c.illegal = 1'b0;
        if (i_opcode[10:3] == OPC_CBZ) begin
            o_dec_c.cls = CLS_CBZ;
        end else if (i_opcode[10:5] == OPC_B) begin
            o_dec_c.cls = CLS_B;
        end else begin
            case (i_opcode)
                OPC_ADD:  o_dec_c.cls = CLS_ADD;
                OPC_SUB:  o_dec_c.cls = CLS_SUB;
                OPC_AND:  o_dec_c.cls = CLS_AND;
                OPC_ORR:  o_dec_c.cls = CLS_ORR;
                OPC_LSL:  o_dec_c.cls = CLS_LSL;
                OPC_LSR:  o_dec_c.cls = CLS_LSR;
                OPC_LDUR: o_dec_c.cls = CLS_LDUR;
                OPC_STUR: o_dec_c.cls = CLS_STUR;
                default:  o_dec_c.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control unit (Moore FSM IDLE/DECODE/EXEC/MEM/WB/FAULT).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   instr_valid, instr      : instruction handshake input (accepted in IDLE)
//   instr_ready             : high in IDLE while out of reset
//   zero                    : ALU zero flag, used by CBZ in EXEC
//   mem_ready               : data memory access complete
//   aluOP, alu_src_b        : ALU operation and B-operand select (EXEC only)
//   reg_write, mem_read,
//   mem_write, pc_write,
//   pc_src                  : datapath enables / PC source select
//   fault                   : 00 none, 01 illegal opcode, 10 memory timeout
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [ALU_W-1:0]  aluOP,
    output logic              alu_src_b,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic [FLT_W-1:0]  fault
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [31:0]       r_instr;
    logic [31:0]       w_instr_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    decode_t           w_dec_c;
    logic              w_is_load;
    logic              w_mem_last;
    logic              w_unused_operands;

    // Only the opcode field steers control; operand fields belong to the datapath.
    assign w_unused_operands = ^r_instr[20:0];

    opcode_decoder u_opcode_decoder (
        .i_opcode (r_instr[31:21]),
        .o_dec_c  (w_dec_c)
    );

    assign w_is_load  = (w_dec_c.cls == CLS_LDUR);
    assign w_mem_last = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // State, instruction and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_instr <= w_instr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next_state = r_state;
        w_instr_next = r_instr;
        w_cnt_next   = r_cnt;
        instr_ready  = 1'b0;
        aluOP        = ALU_ADD;
        alu_src_b    = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        fault        = FLT_NONE;

        case (r_state)
            S_IDLE: begin
                // Gated so the handshake is closed while reset is held.
                instr_ready = rst_n;
                if (instr_valid) begin
                    w_instr_next = instr;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                w_next_state = w_dec_c.illegal ? S_FAULT : S_EXEC;
            end

            S_EXEC: begin
                w_next_state = S_WB;
                case (w_dec_c.cls)
                    CLS_ADD: aluOP = ALU_ADD;
                    CLS_SUB: aluOP = ALU_SUB;
                    CLS_AND: aluOP = ALU_AND;
                    CLS_ORR: aluOP = ALU_ORR;
                    CLS_LSL: begin
                        aluOP     = ALU_LSL;
                        alu_src_b = 1'b1;
                    end
                    CLS_LSR: begin
                        aluOP     = ALU_LSR;
                        alu_src_b = 1'b1;
                    end
                    CLS_LDUR, CLS_STUR: begin
                        alu_src_b    = 1'b1;
                        w_cnt_next   = '0;
                        w_next_state = S_MEM;
                    end
                    CLS_CBZ: begin
                        aluOP        = ALU_PASSB;
                        pc_write     = 1'b1;
                        pc_src       = zero;
                        w_next_state = S_IDLE;
                    end
                    CLS_B: begin
                        pc_write     = 1'b1;
                        pc_src       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                    default: w_next_state = S_FAULT;
                endcase
            end

            S_MEM: begin
                mem_read  = w_is_load;
                mem_write = !w_is_load;
                if (mem_ready) begin
                    if (w_is_load) begin
                        w_next_state = S_WB;
                    end else begin
                        // Store retires in its completing MEM cycle.
                        pc_write     = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end else if (w_mem_last) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                pc_write     = 1'b1;
                w_next_state = S_IDLE;
            end

            S_FAULT: begin
                // Illegal words never reach MEM, so the cause follows from the opcode.
                fault        = w_dec_c.illegal ? FLT_ILLEGAL : FLT_TIMEOUT;
                w_next_state = S_IDLE;
            end

            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  aluOP;
    logic        alu_src_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        pc_src;
    logic [1:0]  fault;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .aluOP       (aluOP),
        .alu_src_b   (alu_src_b),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-transaction summary of what the controller did.
    typedef struct {
        int lat;
        int n_rw;
        int n_mr;
        int n_mw;
        int n_pw;
        int pcsrc;
        int alu;
        int srcb;
        int bad_alu;
        int fault;
        int n_fault;
    } res_t;

    typedef struct {
        logic [31:0] w;
        int          rdy;
        bit          z;
        res_t        e;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input int lat, input int rw, input int mr, input int mw,
                                input int pw, input int pcs, input int alu, input int srcb,
                                input int flt);
        res_t r;
        r.lat = lat; r.n_rw = rw; r.n_mr = mr; r.n_mw = mw; r.n_pw = pw;
        r.pcsrc = pcs; r.alu = alu; r.srcb = srcb; r.bad_alu = 0;
        r.fault = flt; r.n_fault = (flt != 0) ? 1 : 0;
        return r;
    endfunction

    task automatic add_vec(input logic [31:0] w, input int rdy, input bit z, input res_t e);
        vec_t v;
        v.w = w; v.rdy = rdy; v.z = z; v.e = e;
        tbl.push_back(v);
    endtask

    // Reference model: instruction class -> phase counts, from the ISA-level rules.
    function automatic res_t model(input logic [31:0] w, input int rdy, input bit z);
        bit rt = 0, ld = 0, st = 0;
        int alu = 0, srcb = 0, n;
        res_t r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        case (w[31:21])
            11'b10001011000: begin rt = 1; alu = 0; end
            11'b11001011000: begin rt = 1; alu = 1; end
            11'b10001010000: begin rt = 1; alu = 2; end
            11'b10101010000: begin rt = 1; alu = 3; end
            11'b11010011011: begin rt = 1; alu = 5; srcb = 1; end
            11'b11010011010: begin rt = 1; alu = 6; srcb = 1; end
            11'b11111000010: ld = 1;
            11'b11111000000: st = 1;
            default: ;
        endcase
        n = (rdy >= 1 && rdy <= TO) ? rdy : 0;
        if (rt) begin
            r = mk(4, 1, 0, 0, 1, 0, alu, srcb, 0);
        end else if (w[31:24] == 8'hB4) begin
            r = mk(3, 0, 0, 0, 1, int'(z), 4, 0, 0);
        end else if (w[31:26] == 6'b000101) begin
            r = mk(3, 0, 0, 0, 1, 1, 0, 0, 0);
        end else if (ld || st) begin
            if (n > 0)
                r = mk((ld ? 4 : 3) + n, ld ? 1 : 0, ld ? n : 0, st ? n : 0, 1, 0, 0, 1, 0);
            else
                r = mk(3 + TO + 1, 0, ld ? TO : 0, st ? TO : 0, 0, 0, 0, 1, 2);
        end else begin
            r = mk(3, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        return r;
    endfunction

    // Hand one instruction over and observe until the controller is ready again.
    task automatic do_txn(input logic [31:0] w, input int rdy, input bit z, output res_t o);
        int guard = 0;
        o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        o.n_fault = 0;
        @(negedge clk);
        #1;
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!instr_ready) chk("ready_wait", int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            instr_valid = (c <= 2);
            instr       = $urandom;
            zero        = (c == 2) ? z : 1'($urandom_range(0, 1));
            mem_ready   = (rdy > 0 && c == 2 + rdy);
            #1;
            if (instr_ready) begin
                o.lat = c;
                break;
            end
            o.n_rw += int'(reg_write);
            o.n_mr += int'(mem_read);
            o.n_mw += int'(mem_write);
            o.n_pw += int'(pc_write);
            o.pcsrc = o.pcsrc | int'(pc_write & pc_src);
            o.fault = o.fault | int'(fault);
            o.n_fault += (fault != 2'b00) ? 1 : 0;
            if (c == 2) begin
                o.alu  = int'(aluOP);
                o.srcb = int'(alu_src_b);
            end else if (aluOP != 3'b000) begin
                o.bad_alu++;
            end
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t o, input res_t e);
        chk({tag, ".lat"},     o.lat,     e.lat);
        chk({tag, ".rw"},      o.n_rw,    e.n_rw);
        chk({tag, ".mr"},      o.n_mr,    e.n_mr);
        chk({tag, ".mw"},      o.n_mw,    e.n_mw);
        chk({tag, ".pw"},      o.n_pw,    e.n_pw);
        chk({tag, ".pcsrc"},   o.pcsrc,   e.pcsrc);
        chk({tag, ".alu"},     o.alu,     e.alu);
        chk({tag, ".srcb"},    o.srcb,    e.srcb);
        chk({tag, ".bad_alu"}, o.bad_alu, e.bad_alu);
        chk({tag, ".fault"},   o.fault,   e.fault);
        chk({tag, ".nfault"},  o.n_fault, e.n_fault);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        o;
        logic [31:0] w;
        int          rdy;
        bit          z;
        int          sel;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        zero        = 1'b0;
        mem_ready   = 1'b0;

        //        word          rdy z  lat rw mr  mw  pw pcs alu srcb flt
        add_vec(32'h8B020020,  0, 0, mk(4,  1, 0,  0,  1, 0,  0,  0,   0));
        add_vec(32'hCB020020,  0, 0, mk(4,  1, 0,  0,  1, 0,  1,  0,   0));
        add_vec(32'h8A020020,  0, 0, mk(4,  1, 0,  0,  1, 0,  2,  0,   0));
        add_vec(32'hAA020020,  0, 0, mk(4,  1, 0,  0,  1, 0,  3,  0,   0));
        add_vec(32'hD3600000,  0, 0, mk(4,  1, 0,  0,  1, 0,  5,  1,   0));
        add_vec(32'hD3400000,  0, 0, mk(4,  1, 0,  0,  1, 0,  6,  1,   0));
        add_vec(32'hB4000040,  0, 1, mk(3,  0, 0,  0,  1, 1,  4,  0,   0));
        add_vec(32'hB4000040,  0, 0, mk(3,  0, 0,  0,  1, 0,  4,  0,   0));
        add_vec(32'h14000010,  0, 0, mk(3,  0, 0,  0,  1, 1,  0,  0,   0));
        add_vec(32'hF8400020,  3, 0, mk(7,  1, 3,  0,  1, 0,  0,  1,   0));
        add_vec(32'hF8400020,  1, 0, mk(5,  1, 1,  0,  1, 0,  0,  1,   0));
        add_vec(32'hF8400020, 17, 0, mk(20, 0, 16, 0,  0, 0,  0,  1,   2));
        add_vec(32'hF8000020,  0, 0, mk(20, 0, 0,  16, 0, 0,  0,  1,   2));
        add_vec(32'hF8000020,  1, 0, mk(4,  0, 0,  1,  1, 0,  0,  1,   0));
        add_vec(32'hF8000020, 16, 0, mk(19, 0, 0,  16, 1, 0,  0,  1,   0));
        add_vec(32'hFFFFFFFF,  0, 0, mk(3,  0, 0,  0,  0, 0,  0,  0,   1));

        // Reset values while held, then handshake open after release.
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", int'(instr_ready), 0);
        chk("rst.alu",   int'(aluOP),       0);
        chk("rst.en",    int'({reg_write, mem_read, mem_write, pc_write}), 0);
        chk("rst.fault", int'(fault),       0);
        rst_n = 1'b1;
        #1;
        chk("rel.ready", int'(instr_ready), 1);

        foreach (tbl[i]) begin
            do_txn(tbl[i].w, tbl[i].rdy, tbl[i].z, o);
            cmp_res($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset asserted in the middle of an LDUR memory wait.
        @(negedge clk);
        #1;
        chk("mid.ready_pre", int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr       = 32'hF8400020;
        mem_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid.mem_read", int'(mem_read), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_mem_read", int'(mem_read),    0);
        chk("mid.rst_ready",    int'(instr_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid.rel_ready", int'(instr_ready), 1);
        do_txn(32'h8B020020, 0, 0, o);
        cmp_res("mid.add", o, model(32'h8B020020, 0, 0));

        // Random instruction mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            w   = $urandom;
            sel = int'($urandom_range(0, 11));
            case (sel)
                0: w[31:21] = 11'b10001011000;
                1: w[31:21] = 11'b11001011000;
                2: w[31:21] = 11'b10001010000;
                3: w[31:21] = 11'b10101010000;
                4: w[31:21] = 11'b11010011011;
                5: w[31:21] = 11'b11010011010;
                6: w[31:21] = 11'b11111000010;
                7: w[31:21] = 11'b11111000000;
                8: w[31:24] = 8'hB4;
                9: w[31:26] = 6'b000101;
                default: ;
            endcase
            rdy = int'($urandom_range(0, 18));
            z   = 1'($urandom_range(0, 1));
            do_txn(w, rdy, z, o);
            cmp_res($sformatf("rnd%0d", i), o, model(w, rdy, z));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
